// File: rtl/sp_ram_acc_bridge.sv
// sp_ram_acc_bridge
//   Data-port front end for a single-port data RAM. Each core access is decoded to
//   the RAM or to one of NUM_ACC accelerator address windows. RAM accesses are
//   pipelined with one-cycle latency. Accelerator accesses go through a small FSM
//   (IDLE -> ACC_REQ -> ACC_RSP -> RESP) with a req/gnt/rvalid handshake.
//
//   Optional feature: define ACC_TIMEOUT_EN to abort accelerator accesses after
//   ACC_TIMEOUT cycles. An aborted access returns 'hDEADBEEF with err_o=1.
//
// Ports
//   clk, rst_i                      clock, asynchronous active-high reset
//   en_i/addr_i/wdata_i/we_i/be_i   core request (byte address)
//   bypass_en_i                     1 = windows disabled, all accesses go to RAM
//   gnt_o/rvalid_o/rdata_o/err_o    core handshake and response
//   ram_*                           RAM macro port (word address, byte write mask)
//   acc_req_o[k], acc_gnt_i[k], acc_rvalid_i[k], acc_rdata_i[k*DW +: DW]
//                                   per-channel accelerator handshake
//   acc_addr_o/acc_wdata_o/acc_we_o/acc_be_o
//                                   shared registered accelerator request fields
module sp_ram_acc_bridge #(
    parameter int RAM_SIZE     = 32768,
    parameter int ADDR_WIDTH   = $clog2(RAM_SIZE),
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_ACC      = 2,
    parameter int ACC_BASE     = 'h400,
    parameter int ACC_WIN_SIZE = 'h400,
    parameter int ACC_TIMEOUT  = 64
) (
    input  logic                          clk,
    input  logic                          rst_i,
    input  logic                          en_i,
    input  logic [ADDR_WIDTH-1:0]         addr_i,
    input  logic [DATA_WIDTH-1:0]         wdata_i,
    input  logic                          we_i,
    input  logic [DATA_WIDTH/8-1:0]       be_i,
    input  logic                          bypass_en_i,
    output logic                          gnt_o,
    output logic                          rvalid_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          err_o,
    output logic                          ram_en_o,
    output logic [ADDR_WIDTH-3:0]         ram_addr_o,
    output logic [DATA_WIDTH-1:0]         ram_wdata_o,
    output logic [DATA_WIDTH/8-1:0]       ram_we_o,
    input  logic [DATA_WIDTH-1:0]         ram_rdata_i,
    output logic [NUM_ACC-1:0]            acc_req_o,
    output logic [ADDR_WIDTH-1:0]         acc_addr_o,
    output logic [DATA_WIDTH-1:0]         acc_wdata_o,
    output logic                          acc_we_o,
    output logic [DATA_WIDTH/8-1:0]       acc_be_o,
    input  logic [NUM_ACC-1:0]            acc_gnt_i,
    input  logic [NUM_ACC-1:0]            acc_rvalid_i,
    input  logic [NUM_ACC*DATA_WIDTH-1:0] acc_rdata_i
);

    localparam int BE_W = DATA_WIDTH / 8;
    localparam int CH_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;

    typedef enum logic [1:0] {IDLE, ACC_REQ, ACC_RSP, RESP} state_e;

    state_e                  state_q, state_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    we_q, we_d;
    logic [BE_W-1:0]         be_q, be_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    ram_vld_q;

    // Returns {hit, channel}; addresses above the last window fall through to RAM.
    function automatic logic [CH_W:0] decode(input logic [ADDR_WIDTH-1:0] a);
        logic [31:0] ae;
        logic [31:0] lo;
        decode = '0;
        ae = 32'(a);
        for (int k = 0; k < NUM_ACC; k++) begin
            lo = 32'(ACC_BASE) + 32'(k) * 32'(ACC_WIN_SIZE);
            if (ae >= lo && ae < lo + 32'(ACC_WIN_SIZE)) begin
                decode = {1'b1, CH_W'(k)};
            end
        end
    endfunction

    logic [CH_W:0]         dec;
    logic                  acc_hit;
    logic [CH_W-1:0]       hit_ch;
    logic [31:0]           win_base;
    logic [ADDR_WIDTH-1:0] win_off;
    logic                  gnt;

    assign dec      = bypass_en_i ? '0 : decode(addr_i);
    assign acc_hit  = dec[CH_W];
    assign hit_ch   = dec[CH_W-1:0];
    assign win_base = 32'(ACC_BASE) + 32'(hit_ch) * 32'(ACC_WIN_SIZE);
    assign win_off  = ADDR_WIDTH'(32'(addr_i) - win_base);

    // Grant is gated by reset so nothing is accepted while rst_i is held.
    assign gnt   = en_i && (state_q == IDLE) && !rst_i;
    assign gnt_o = gnt;

    assign ram_en_o    = gnt && !acc_hit;
    assign ram_addr_o  = addr_i[ADDR_WIDTH-1:2];
    assign ram_wdata_o = wdata_i;
    assign ram_we_o    = ram_en_o ? (be_i & {BE_W{we_i}}) : '0;

    // Select the handshake of the channel owning the current access.
    logic                  sel_gnt, sel_rvalid;
    logic [DATA_WIDTH-1:0] sel_rdata;

    always_comb begin
        sel_gnt    = 1'b0;
        sel_rvalid = 1'b0;
        sel_rdata  = '0;
        acc_req_o  = '0;
        for (int k = 0; k < NUM_ACC; k++) begin
            if (ch_q == CH_W'(k)) begin
                sel_gnt      = acc_gnt_i[k];
                sel_rvalid   = acc_rvalid_i[k];
                sel_rdata    = acc_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
                acc_req_o[k] = (state_q == ACC_REQ);
            end
        end
    end

`ifdef ACC_TIMEOUT_EN
    localparam int CNT_W = $clog2(ACC_TIMEOUT) + 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             expire;

    assign expire = (cnt_q == CNT_W'(ACC_TIMEOUT - 1));
    assign err_o  = (state_q == RESP) && err_q;
`else
    assign err_o  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        be_d    = be_q;
        rdata_d = rdata_q;
`ifdef ACC_TIMEOUT_EN
        cnt_d = cnt_q;
        err_d = err_q;
        // Cleared while idle so it starts at 0 in the first ACC_REQ cycle;
        // saturates at the expiry value.
        if (state_q == IDLE) begin
            cnt_d = '0;
            err_d = 1'b0;
        end else if (state_q != RESP && !expire) begin
            cnt_d = cnt_q + 1'b1;
        end
`endif
        unique case (state_q)
            IDLE: begin
                if (gnt && acc_hit) begin
                    state_d = ACC_REQ;
                    ch_d    = hit_ch;
                    addr_d  = win_off;
                    wdata_d = wdata_i;
                    we_d    = we_i;
                    be_d    = be_i;
                end
            end
            ACC_REQ: begin
                if (sel_gnt) begin
                    state_d = ACC_RSP;
                end
`ifdef ACC_TIMEOUT_EN
                else if (expire) begin
                    state_d = RESP;
                    rdata_d = DATA_WIDTH'(32'hDEADBEEF);
                    err_d   = 1'b1;
                end
`endif
            end
            ACC_RSP: begin
                // A response arriving together with expiry takes priority.
                if (sel_rvalid) begin
                    state_d = RESP;
                    rdata_d = sel_rdata;
                end
`ifdef ACC_TIMEOUT_EN
                else if (expire) begin
                    state_d = RESP;
                    rdata_d = DATA_WIDTH'(32'hDEADBEEF);
                    err_d   = 1'b1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            rdata_q   <= '0;
            ram_vld_q <= 1'b0;
`ifdef ACC_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            be_q      <= be_d;
            rdata_q   <= rdata_d;
            ram_vld_q <= ram_en_o;
`ifdef ACC_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign acc_addr_o  = addr_q;
    assign acc_wdata_o = wdata_q;
    assign acc_we_o    = we_q;
    assign acc_be_o    = be_q;

    // A RAM response always leaves before RESP can be reached, so the two never overlap.
    assign rvalid_o = ram_vld_q || (state_q == RESP);
    assign rdata_o  = ram_vld_q ? ram_rdata_i :
                      (state_q == RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_sp_ram_acc_bridge.sv
module tb_sp_ram_acc_bridge;

    localparam int AW     = 15;
    localparam int DW     = 32;
    localparam int NA     = 2;
    localparam int ACC_TO = 8;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             en_i;
    logic [AW-1:0]    addr_i;
    logic [DW-1:0]    wdata_i;
    logic             we_i;
    logic [3:0]       be_i;
    logic             bypass_en_i;
    logic             gnt_o, rvalid_o, err_o, ram_en_o;
    logic [DW-1:0]    rdata_o;
    logic [AW-3:0]    ram_addr_o;
    logic [DW-1:0]    ram_wdata_o;
    logic [3:0]       ram_we_o;
    logic [DW-1:0]    ram_rdata_i;
    logic [NA-1:0]    acc_req_o;
    logic [AW-1:0]    acc_addr_o;
    logic [DW-1:0]    acc_wdata_o;
    logic             acc_we_o;
    logic [3:0]       acc_be_o;
    logic [NA-1:0]    acc_gnt_i;
    logic [NA-1:0]    acc_rvalid_i;
    logic [NA*DW-1:0] acc_rdata_i;

    sp_ram_acc_bridge #(
        .RAM_SIZE(32768), .DATA_WIDTH(DW), .NUM_ACC(NA),
        .ACC_BASE('h400), .ACC_WIN_SIZE('h400), .ACC_TIMEOUT(ACC_TO)
    ) dut (
        .clk(clk), .rst_i(rst_i), .en_i(en_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .we_i(we_i), .be_i(be_i), .bypass_en_i(bypass_en_i), .gnt_o(gnt_o),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o), .ram_en_o(ram_en_o),
        .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_we_o(ram_we_o),
        .ram_rdata_i(ram_rdata_i), .acc_req_o(acc_req_o), .acc_addr_o(acc_addr_o),
        .acc_wdata_o(acc_wdata_o), .acc_we_o(acc_we_o), .acc_be_o(acc_be_o),
        .acc_gnt_i(acc_gnt_i), .acc_rvalid_i(acc_rvalid_i), .acc_rdata_i(acc_rdata_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM macro stand-in: registered read, byte-masked write.
    logic [DW-1:0] mem [0:8191];
    always @(posedge clk) begin
        if (ram_en_o) begin
            for (int b = 0; b < 4; b++)
                if (ram_we_o[b]) mem[ram_addr_o][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
            ram_rdata_i <= mem[ram_addr_o];
        end
    end

    // Reference memory kept by the bench to form expected read data.
    logic [DW-1:0] ref_mem [0:8191];

    typedef struct {
        logic [31:0] data;
        logic        chk_data;
        logic        err;
        int          due;
    } exp_t;
    exp_t sb[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        else n_pass++;
    endtask

    // Response monitor: pops the scoreboard on every rvalid_o.
    always @(negedge clk) begin
        if (!rst_i && rvalid_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk_data) chk("rdata", rdata_o, e.data);
                chk("err", err_o, e.err);
                if (e.due != 0) chk("latency", cyc, e.due);
            end
        end
    end

    task automatic idle();
        en_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound && sb.size() != 0; i++) @(negedge clk);
        chk("drain", sb.size(), 0);
    endtask

    // Issues one RAM access; leaves en_i asserted so calls can run back to back.
    task automatic ram_acc(input logic [AW-1:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] be);
        exp_t e;
        en_i = 1'b1; addr_i = a; we_i = w; wdata_i = d; be_i = be;
        #1;
        chk("ram_gnt", gnt_o, 1);
        chk("ram_en", ram_en_o, 1);
        chk("ram_addr", ram_addr_o, a[AW-1:2]);
        chk("ram_we", ram_we_o, w ? be : 4'h0);
        chk("ram_no_acc", acc_req_o, 0);
        e.data = ref_mem[a[AW-1:2]]; e.chk_data = !w; e.err = 1'b0; e.due = cyc + 1;
        if (w)
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[a[AW-1:2]][b*8 +: 8] = d[b*8 +: 8];
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Full accelerator access with gdly wait cycles before grant and rdly cycles
    // from grant to response. Expected latency grant->rvalid is gdly+rdly+2.
    task automatic acc_acc(input logic [AW-1:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] be, input int ch, input logic [AW-1:0] off,
                           input int gdly, input int rdly, input logic [31:0] rd);
        exp_t e;
        en_i = 1'b1; addr_i = a; we_i = w; wdata_i = d; be_i = be;
        #1;
        chk("acc_gnt", gnt_o, 1);
        chk("acc_no_ram", ram_en_o, 0);
        e.data = rd; e.chk_data = 1'b1; e.err = 1'b0; e.due = cyc + gdly + rdly + 2;
        sb.push_back(e);
        @(negedge clk);
        // Keep a RAM request pending to confirm nothing is granted mid-access.
        addr_i = 15'h0010; we_i = 1'b0; wdata_i = 32'h0;
        for (int i = 0; i <= gdly; i++) begin
            #1;
            chk("acc_req", acc_req_o, NA'(1) << ch);
            chk("busy_gnt", gnt_o, 0);
            chk("acc_addr", acc_addr_o, off);
            chk("acc_wdata", acc_wdata_o, d);
            chk("acc_we", acc_we_o, w);
            chk("acc_be", acc_be_o, be);
            if (i == gdly) acc_gnt_i = NA'(1) << ch;
            @(negedge clk);
        end
        acc_gnt_i = '0;
        for (int i = 0; i < rdly; i++) begin
            #1;
            chk("rsp_req_low", acc_req_o, 0);
            chk("rsp_gnt", gnt_o, 0);
            if (i == rdly - 1) begin
                acc_rvalid_i = NA'(1) << ch;
                acc_rdata_i  = {NA{32'h5A5A_F00D}};
                acc_rdata_i[ch*DW +: DW] = rd;
            end
            @(negedge clk);
        end
        acc_rvalid_i = '0;
        en_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        rst_i = 1'b1; en_i = 1'b1; addr_i = '0; wdata_i = '0; we_i = 1'b0; be_i = 4'hF;
        bypass_en_i = 1'b0; acc_gnt_i = '0; acc_rvalid_i = '0; acc_rdata_i = '0;
        ram_rdata_i = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt", gnt_o, 0);
        chk("rst_ram_en", ram_en_o, 0);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_acc_req", acc_req_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_acc_addr", acc_addr_o, 0);
        en_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);

        // Write then read at 0x000.
        ram_acc(15'h000, 1'b1, 32'hA5A5_0001, 4'hF);
        ram_acc(15'h000, 1'b0, 32'h0, 4'hF);
        idle();
        wait_drain(10);

        // Back-to-back RAM traffic with partial byte enables.
        for (int i = 0; i < 6; i++)
            ram_acc(15'(16 + 4 * i), 1'b1, $urandom, 4'(i + 1));
        for (int i = 0; i < 6; i++)
            ram_acc(15'(16 + 4 * i), 1'b0, 32'h0, 4'hF);
        idle();
        wait_drain(10);

        // Accelerator read of 0x404: grant 2 cycles late, response 3 cycles after grant.
        acc_acc(15'h404, 1'b0, 32'h0, 4'hF, 0, 15'h004, 2, 3, 32'h0000_1234);
        wait_drain(10);

        // Decode boundaries.
        ram_acc(15'h3FC, 1'b0, 32'h0, 4'hF);
        idle();
        wait_drain(10);
        acc_acc(15'h400, 1'b0, 32'h0, 4'hF, 0, 15'h000, 0, 1, 32'hC0DE_0400);
        acc_acc(15'h7FC, 1'b1, 32'hFEED_07FC, 4'h3, 0, 15'h3FC, 1, 1, 32'h0);
        acc_acc(15'h800, 1'b0, 32'h0, 4'hF, 1, 15'h000, 0, 2, 32'hC0DE_0800);
        acc_acc(15'hBFC, 1'b1, 32'h1357_9BDF, 4'hC, 1, 15'h3FC, 2, 1, 32'h1111_2222);
        ram_acc(15'hC00, 1'b1, 32'h0BAD_0C00, 4'hF);
        ram_acc(15'hC00, 1'b0, 32'h0, 4'hF);
        idle();
        wait_drain(10);

        // Bypass: 0x404 goes to RAM.
        bypass_en_i = 1'b1;
        ram_acc(15'h404, 1'b1, 32'h4040_4040, 4'hF);
        ram_acc(15'h404, 1'b0, 32'h0, 4'hF);
        idle();
        chk("bypass_acc_req", acc_req_o, 0);
        wait_drain(10);
        bypass_en_i = 1'b0;

`ifdef ACC_TIMEOUT_EN
        // Silent channel 1: abort after ACC_TO cycles.
        begin
            exp_t e;
            en_i = 1'b1; addr_i = 15'h0900; we_i = 1'b0; be_i = 4'hF;
            #1;
            chk("to_gnt", gnt_o, 1);
            e.data = 32'hDEAD_BEEF; e.chk_data = 1'b1; e.err = 1'b1; e.due = cyc + ACC_TO + 1;
            sb.push_back(e);
            @(negedge clk);
            en_i = 1'b0;
            #1;
            chk("to_req", acc_req_o, 2'b10);
            wait_drain(ACC_TO + 10);
            chk("to_req_drop", acc_req_o, 0);
            ram_acc(15'h000, 1'b0, 32'h0, 4'hF);
            idle();
            wait_drain(10);
        end
`endif

        // Reset during ACC_REQ drops the request immediately.
        en_i = 1'b1; addr_i = 15'h0404; we_i = 1'b1; wdata_i = 32'h7777_7777; be_i = 4'hF;
        @(negedge clk);
        en_i = 1'b0;
        #1;
        chk("pre_rst_req", acc_req_o, 2'b01);
        rst_i = 1'b1;
        #1;
        chk("rst_req_drop", acc_req_o, 0);
        chk("rst_req_wdata", acc_wdata_o, 0);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);

        // Reset during ACC_RSP: no response, then a normal RAM read at 0x010.
        en_i = 1'b1; addr_i = 15'h0404; we_i = 1'b0; be_i = 4'hF;
        @(negedge clk);
        en_i = 1'b0;
        acc_gnt_i = 2'b01;
        @(negedge clk);
        acc_gnt_i = '0;
        #1;
        rst_i = 1'b1;
        #1;
        chk("rst_rsp_req", acc_req_o, 0);
        chk("rst_rsp_rvalid", rvalid_o, 0);
        chk("rst_rsp_addr", acc_addr_o, 0);
        @(negedge clk);
        rst_i = 1'b0;
        acc_rvalid_i = 2'b01;
        acc_rdata_i  = {NA{32'hBAD0_BAD0}};
        @(negedge clk);
        acc_rvalid_i = '0;
        #1;
        chk("post_rst_gnt_idle", rvalid_o, 0);
        ram_acc(15'h010, 1'b0, 32'h0, 4'hF);
        idle();
        wait_drain(10);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
